instr_sequencer: RTL

- Program sequencer that drives the address of the combinational instruction ROM and decodes each returned 2*WIDTH-bit word.
- Handles jumps, conditional jumps, timed waits and halt.
- Issues datapath commands to the game execution unit over a valid/ready handshake.
- Sits between the instruction ROM (pc_addr feeds its curr_command; rom_data is its out_data) and the tetris datapath.

---
 rtl/instr_sequencer.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// Program sequencer for the instruction ROM. It drives the ROM address, decodes
// each returned word and issues EXEC commands to the datapath over a
// valid/ready handshake. It also handles jumps, conditional jumps, timed waits
// and halt.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   start      one-cycle request to run from address 0 (IDLE/HALTED only)
//   rom_data   instruction word {op field, operand}, combinational on pc_addr
//   cond_flag  datapath condition; JZ jumps when it is 0
//   exec_ready execution unit accepts the pending command
//   pc_addr    program counter / ROM address
//   exec_valid command pending on exec_op/exec_data
//   exec_op    upper half of the issued EXEC word
//   exec_data  lower half of the issued EXEC word
//   busy       high in FETCH, ISSUE and DELAY
//   halted     high in HALTED
//   err        sticky flag, set by an out-of-range jump target
module instr_sequencer #(
  parameter int unsigned WIDTH               = 8,
  parameter int unsigned INSTRACTION_NUMBERS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] rom_data,
  input  logic               cond_flag,
  input  logic               exec_ready,
  output logic [WIDTH-1:0]   pc_addr,
  output logic               exec_valid,
  output logic [WIDTH-1:0]   exec_op,
  output logic [WIDTH-1:0]   exec_data,
  output logic               busy,
  output logic               halted,
  output logic               err
);

  localparam logic [WIDTH-1:0] LastPc = WIDTH'(INSTRACTION_NUMBERS - 1);

  localparam logic [2:0] OpExec = 3'd1;
  localparam logic [2:0] OpJmp  = 3'd2;
  localparam logic [2:0] OpJz   = 3'd3;
  localparam logic [2:0] OpWait = 3'd4;
  localparam logic [2:0] OpHalt = 3'd5;

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StDelay, StHalted} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             err_q, err_d;

  logic [2:0]       op;
  logic [WIDTH-1:0] operand;
  logic [WIDTH-1:0] pc_inc;
  logic             target_ok;

  assign op        = rom_data[WIDTH+2:WIDTH];
  assign operand   = rom_data[WIDTH-1:0];
  assign pc_inc    = (pc_q == LastPc) ? '0 : pc_q + 1'b1;
  assign target_ok = (operand <= LastPc);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    op_d    = op_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      StIdle, StHalted: begin
        if (start) begin
          pc_d    = '0;
          err_d   = 1'b0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        case (op)
          OpExec: begin
            op_d    = rom_data[2*WIDTH-1:WIDTH];
            data_d  = operand;
            valid_d = 1'b1;
            state_d = StIssue;
          end
          OpJmp, OpJz: begin
            // JZ with cond_flag set falls through; otherwise both take the jump.
            if (op == OpJz && cond_flag) begin
              pc_d = pc_inc;
            end else if (target_ok) begin
              pc_d = operand;
            end else begin
              err_d   = 1'b1;
              state_d = StHalted;
            end
          end
          OpWait: begin
            if (operand == '0) begin
              pc_d = pc_inc;
            end else begin
              cnt_d   = operand;
              state_d = StDelay;
            end
          end
          OpHalt:  state_d = StHalted;
          default: pc_d = pc_inc;
        endcase
      end
      StIssue: begin
        if (exec_ready) begin
          valid_d = 1'b0;
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      StDelay: begin
        if (cnt_q == WIDTH'(1)) begin
          pc_d    = pc_inc;
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Status flags are registered from the next state so they track state_q.
    busy_d   = (state_d == StFetch) || (state_d == StIssue) || (state_d == StDelay);
    halted_d = (state_d == StHalted);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
      op_q     <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      op_q     <= op_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      err_q    <= err_d;
    end
  end

  assign pc_addr    = pc_q;
  assign exec_valid = valid_q;
  assign exec_op    = op_q;
  assign exec_data  = data_q;
  assign busy       = busy_q;
  assign halted     = halted_q;
  assign err        = err_q;

endmodule
